int_decl_emitter: RTL and testbench

INT_DECL_EMITTER -- requirements
Module: int_decl_emitter

---
 rtl/int_decl_emitter.sv | 138 +++++++++++++
 tb/tb_int_decl_emitter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/int_decl_emitter.sv
// int_decl_emitter: streams a C-style declaration "int a,b,...;" one ASCII
// character per transfer over a valid/ready handshake.
// Optional feature: define SPACE_AFTER_COMMA_EN to emit a ' ' after each ','
// (adds state SP2, giving "int a, b;").
module int_decl_emitter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cnt,
    input  logic       ready,
    output logic [7:0] out,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        IDLE,
        KW_I,
        KW_N,
        KW_T,
        SP,
        ID,
        SEP,
`ifdef SPACE_AFTER_COMMA_EN
        SP2,
`endif
        SEMI,
        FIN
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;     // identifier index, 0..14
    logic [3:0] n_q, n_d;         // latched identifier count, 1..15
    logic [7:0] out_q, out_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic xfer;
    logic more_ids;

    assign xfer     = valid_q & ready;
    assign more_ids = (idx_q < (n_q - 4'd1));

    // Next-state logic: advance one character per accepted transfer.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = KW_I;
                    idx_d   = 4'd0;
                    n_d     = (cnt == 4'd0) ? 4'd1 : cnt;
                end
            end
            KW_I: if (xfer) state_d = KW_N;
            KW_N: if (xfer) state_d = KW_T;
            KW_T: if (xfer) state_d = SP;
            SP:   if (xfer) state_d = ID;
            ID: begin
                if (xfer) state_d = more_ids ? SEP : SEMI;
            end
`ifdef SPACE_AFTER_COMMA_EN
            SEP:  if (xfer) state_d = SP2;
            SP2: begin
                if (xfer) begin
                    state_d = ID;
                    idx_d   = idx_q + 4'd1;
                end
            end
`else
            SEP: begin
                if (xfer) begin
                    state_d = ID;
                    idx_d   = idx_q + 4'd1;
                end
            end
`endif
            SEMI: if (xfer) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so outputs are registered with it.
    always_comb begin
        out_d   = 8'h00;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            KW_I: begin out_d = 8'h69; valid_d = 1'b1; busy_d = 1'b1; end
            KW_N: begin out_d = 8'h6E; valid_d = 1'b1; busy_d = 1'b1; end
            KW_T: begin out_d = 8'h74; valid_d = 1'b1; busy_d = 1'b1; end
            SP:   begin out_d = 8'h20; valid_d = 1'b1; busy_d = 1'b1; end
            ID:   begin out_d = 8'h61 + {4'h0, idx_d}; valid_d = 1'b1; busy_d = 1'b1; end
            SEP:  begin out_d = 8'h2C; valid_d = 1'b1; busy_d = 1'b1; end
`ifdef SPACE_AFTER_COMMA_EN
            SP2:  begin out_d = 8'h20; valid_d = 1'b1; busy_d = 1'b1; end
`endif
            SEMI: begin out_d = 8'h3B; valid_d = 1'b1; busy_d = 1'b1; end
            FIN:  done_d = 1'b1;
            default: ;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            n_q     <= 4'd1;
            out_q   <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_int_decl_emitter.sv
// Self-checking bench for int_decl_emitter: directed scenarios plus randomized
// streams (random cnt, random ready back-pressure, stray start pulses),
// compared against an expected byte queue built from the declaration text.
module tb_int_decl_emitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] cnt;
    logic       ready;
    logic [7:0] out;
    logic       valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    int_decl_emitter dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .cnt   (cnt),
        .ready (ready),
        .out   (out),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected text: "int " then identifiers joined by "," (", " with the option), then ";".
    task automatic build_expected(input int c);
        int n;
        n = (c == 0) ? 1 : c;
        exp_q.delete();
        exp_q.push_back("i");
        exp_q.push_back("n");
        exp_q.push_back("t");
        exp_q.push_back(" ");
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                exp_q.push_back(",");
`ifdef SPACE_AFTER_COMMA_EN
                exp_q.push_back(" ");
`endif
            end
            exp_q.push_back(8'(8'h61 + k));
        end
        exp_q.push_back(";");
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"},  busy,  0);
        check({tag, "_done"},  done,  0);
        check({tag, "_out"},   out,   0);
    endtask

    // One stream: rand_ready gives random back-pressure; stall_on/stall_n
    // holds ready low while that character is offered; abort_on applies
    // reset when that character is offered; noise toggles start/cnt mid-stream.
    task automatic run_stream(input int c, input bit rand_ready,
                              input logic [7:0] stall_on, input int stall_n,
                              input logic [7:0] abort_on, input bit noise);
        int exp_len;
        int cycles  = 0;
        int stalls  = 0;
        int stalled = 0;
        build_expected(c);
        exp_len = exp_q.size();
        start = 1'b1;
        cnt   = 4'(c);
        ready = 1'b1;
        tick();
        start = 1'b0;
        check("first_char", out, 8'h69);
        while (exp_q.size() > 0 && cycles < 400) begin
            check("valid", valid, 1);
            check("busy",  busy,  1);
            check("done",  done,  0);
            check("out",   out,   exp_q[0]);
            cycles++;
            if (abort_on != 8'h00 && out == abort_on) begin
                reset = 1'b0;
                start = 1'b1;   // must be ignored together with reset
                cnt   = 4'(c);
                tick();
                check_idle("abort");
                reset = 1'b1;
                start = 1'b0;
                tick();
                check_idle("post_abort");
                exp_q.delete();
                return;
            end
            if (stall_n > 0 && out == stall_on && stalled < stall_n) begin
                ready = 1'b0;
                stalled++;
            end else if (rand_ready) begin
                ready = ($urandom_range(3, 0) != 0);
            end else begin
                ready = 1'b1;
            end
            if (!ready) stalls++;
            if (noise) begin
                start = 1'($urandom_range(1, 0));
                cnt   = 4'($urandom_range(15, 0));
            end
            tick();
            if (ready) void'(exp_q.pop_front());
        end
        check("stream_complete", exp_q.size(), 0);
        check("stream_cycles", cycles, exp_len + stalls);
        check("fin_done",  done,  1);
        check("fin_valid", valid, 0);
        check("fin_busy",  busy,  0);
        check("fin_out",   out,   0);
        start = noise ? 1'b1 : 1'b0;   // start in FIN is ignored
        tick();
        start = 1'b0;
        check_idle("idle_after");
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        cnt   = 4'd0;
        ready = 1'b1;
        tick();
        start = 1'b1;   // start during reset is ignored
        cnt   = 4'd3;
        tick();
        check_idle("reset");
        reset = 1'b1;
        start = 1'b0;
        tick();
        check_idle("reset_release");

        run_stream(1, 1'b0, 8'h00, 0, 8'h00, 1'b0);   // "int a;"
        run_stream(3, 1'b0, 8'h00, 0, 8'h00, 1'b0);   // "int a,b,c;"
        run_stream(2, 1'b0, "n",   3, 8'h00, 1'b0);   // stall on 'n'
        run_stream(5, 1'b0, 8'h00, 0, "c",   1'b0);   // reset mid-stream
        run_stream(0, 1'b0, 8'h00, 0, 8'h00, 1'b0);   // cnt=0 -> "int a;"
        run_stream(15, 1'b0, 8'h00, 0, 8'h00, 1'b0);  // longest stream, up to 'o'
        run_stream(3, 1'b0, 8'h00, 0, 8'h00, 1'b1);   // start/cnt noise while busy

        for (int i = 0; i < 40; i++) begin
            run_stream(int'($urandom_range(15, 0)), 1'b1, 8'h00, 0, 8'h00,
                       1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
